// File: rtl/riscv_instr_encoder.sv
// riscv_instr_encoder: turns a decoded micro-op back into a 32-bit RV32I word.
// One registered stage with valid/ready on both sides. Each word is tagged with
// an address from an internal word-address counter.
// Optional feature macro: ENC_ILLEGAL_COUNT_EN adds a saturating 8-bit illegal_cnt output.
module riscv_instr_encoder #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_class,
    input  logic [3:0]        in_alu_ctrl,
    input  logic [2:0]        in_width,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_illegal
`ifdef ENC_ILLEGAL_COUNT_EN
    ,
    output logic [7:0]        illegal_cnt
`endif
);

    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_IALU   = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_JAL    = 4'd5,
        CLS_JALR   = 4'd6,
        CLS_LUI    = 4'd7,
        CLS_AUIPC  = 4'd8
    } cls_e;

    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_IALU   = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_illegal_q, out_illegal_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;

    logic        accept;
    logic [31:0] enc_instr;
    logic        enc_illegal;
    logic        fits12, fits13, fits21, shamt_ok, low12_zero;
    logic [6:0]  funct7;
    logic [2:0]  br_f3;
    logic        br_ok;
    logic        r_ok;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Immediate range checks: upper bits must be a pure sign extension.
    assign fits12     = (&in_imm[31:11]) || !(|in_imm[31:11]);
    assign fits13     = (&in_imm[31:12]) || !(|in_imm[31:12]);
    assign fits21     = (&in_imm[31:20]) || !(|in_imm[31:20]);
    assign shamt_ok   = !(|in_imm[31:5]);
    assign low12_zero = !(|in_imm[11:0]);
    assign funct7     = (in_alu_ctrl == 4'b1000 || in_alu_ctrl == 4'b1101) ? 7'b0100000 : 7'b0000000;
    assign r_ok       = !in_alu_ctrl[3] || in_alu_ctrl == 4'b1000 || in_alu_ctrl == 4'b1101;

    // Branch code to B-type funct3 translation.
    always_comb begin
        br_f3 = 3'b000;
        br_ok = 1'b1;
        case (in_alu_ctrl)
            4'b1000: br_f3 = 3'b000;
            4'b1001: br_f3 = 3'b001;
            4'b1010: br_f3 = 3'b100;
            4'b1011: br_f3 = 3'b101;
            4'b1100: br_f3 = 3'b110;
            4'b1101: br_f3 = 3'b111;
            default: br_ok = 1'b0;
        endcase
    end

    // Field packing per instruction class; anything unencodable becomes a NOP.
    always_comb begin
        enc_instr   = NOP_WORD;
        enc_illegal = 1'b1;
        case (in_class)
            CLS_R: begin
                if (r_ok) begin
                    enc_instr   = {funct7, in_rs2, in_rs1, in_alu_ctrl[2:0], in_rd, OP_R};
                    enc_illegal = 1'b0;
                end
            end
            CLS_IALU: begin
                case (in_alu_ctrl)
                    4'b0000, 4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b0111: begin
                        if (fits12) begin
                            enc_instr   = {in_imm[11:0], in_rs1, in_alu_ctrl[2:0], in_rd, OP_IALU};
                            enc_illegal = 1'b0;
                        end
                    end
                    4'b0001, 4'b0101, 4'b1101: begin
                        if (shamt_ok) begin
                            enc_instr   = {funct7, in_imm[4:0], in_rs1, in_alu_ctrl[2:0], in_rd, OP_IALU};
                            enc_illegal = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            CLS_LOAD: begin
                if (fits12 && (in_width == 3'b000 || in_width == 3'b001 || in_width == 3'b010 ||
                               in_width == 3'b100 || in_width == 3'b101)) begin
                    enc_instr   = {in_imm[11:0], in_rs1, in_width, in_rd, OP_LOAD};
                    enc_illegal = 1'b0;
                end
            end
            CLS_STORE: begin
                if (fits12 && (in_width == 3'b000 || in_width == 3'b001 || in_width == 3'b010)) begin
                    enc_instr   = {in_imm[11:5], in_rs2, in_rs1, in_width, in_imm[4:0], OP_STORE};
                    enc_illegal = 1'b0;
                end
            end
            CLS_BRANCH: begin
                if (br_ok && fits13 && !in_imm[0]) begin
                    enc_instr   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, br_f3,
                                   in_imm[4:1], in_imm[11], OP_BRANCH};
                    enc_illegal = 1'b0;
                end
            end
            CLS_JAL: begin
                if (fits21 && !in_imm[0]) begin
                    enc_instr   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
                    enc_illegal = 1'b0;
                end
            end
            CLS_JALR: begin
                if (fits12) begin
                    enc_instr   = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
                    enc_illegal = 1'b0;
                end
            end
            CLS_LUI, CLS_AUIPC: begin
                if (low12_zero) begin
                    enc_instr   = {in_imm[31:12], in_rd, (in_class == CLS_LUI) ? OP_LUI : OP_AUIPC};
                    enc_illegal = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Next-state for the output stage and the address counter; base_load beats increment.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        out_addr_d    = out_addr_q;
        out_illegal_d = out_illegal_q;
        next_addr_d   = next_addr_q;
        if (accept) begin
            out_valid_d   = 1'b1;
            out_instr_d   = enc_instr;
            out_illegal_d = enc_illegal;
        end else if (out_ready) begin
            out_valid_d   = 1'b0;
        end
        if (base_load) begin
            if (accept) begin
                out_addr_d  = base_addr;
                next_addr_d = base_addr + ADDR_W'(1);
            end else begin
                next_addr_d = base_addr;
            end
        end else if (accept) begin
            out_addr_d  = next_addr_q;
            next_addr_d = next_addr_q + ADDR_W'(1);
        end
    end

    // Pipeline and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_instr_q   <= '0;
            out_addr_q    <= '0;
            out_illegal_q <= 1'b0;
            next_addr_q   <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_addr_q    <= out_addr_d;
            out_illegal_q <= out_illegal_d;
            next_addr_q   <= next_addr_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_addr    = out_addr_q;
    assign out_illegal = out_illegal_q;

`ifdef ENC_ILLEGAL_COUNT_EN
    logic [7:0] illegal_cnt_q, illegal_cnt_d;

    // Saturating count of accepted illegal micro-ops, cleared by base_load.
    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (base_load) begin
            illegal_cnt_d = (accept && enc_illegal) ? 8'd1 : 8'd0;
        end else if (accept && enc_illegal && illegal_cnt_q != 8'hFF) begin
            illegal_cnt_d = illegal_cnt_q + 8'd1;
        end
    end

    // Illegal counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_cnt_q <= '0;
        end else begin
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign illegal_cnt = illegal_cnt_q;
`endif

endmodule
